// File: rtl/vram_dbuf_bank.sv
// rtl/vram_dbuf_bank.sv - double-buffered VRAM bank: PPU reads front, CPU owns back, swap at vblank
// Front/back halves share one true-dual-port RAM; an optional copy engine resyncs back from front.
module vram_dbuf_bank #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 10,
  parameter int SYNC_ON_SWAP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ppu_rd_en,
  input  logic [ADDR_W-1:0]   ppu_rd_addr,
  output logic [DATA_W-1:0]   ppu_rd_data,
  input  logic                cpu_wren,
  input  logic                cpu_rden,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wrdata,
  input  logic [DATA_W/8-1:0] cpu_byteena,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_rddata,
  output logic                cpu_rdvalid,
  input  logic                swap_req,
  input  logic                vblank_start,
  output logic                swap_pending,
  output logic                copy_busy,
  output logic                swap_done,
  output logic                front_sel
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_COPY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_front_sel;
  logic [ADDR_W:0]     r_cp_idx;
  logic                r_cp_wr_pend;
  logic [ADDR_W-1:0]   r_cp_waddr;
  logic                r_swap_done;
  logic                r_cpu_rdvalid;
  logic [DATA_W-1:0]   r_q_a;
  logic [DATA_W-1:0]   r_q_b;
  logic [DATA_W-1:0]   r_mem [0:2*DEPTH-1];

  logic                w_swap_now;
  logic                w_swap_done_nxt;
  logic                w_copy_last;
  logic                w_cp_issue;
  logic                w_cpu_ready;
  logic                w_cpu_wr;
  logic                w_cpu_rd;
  logic                w_a_re;
  logic [ADDR_W:0]     w_addr_a;
  logic                w_b_we;
  logic [ADDR_W:0]     w_addr_b;
  logic [DATA_W-1:0]   w_b_data;
  logic [NB-1:0]       w_b_be;

  assign w_cpu_ready = (r_state != S_COPY);
  assign w_cpu_wr    = w_cpu_ready & cpu_wren;
  assign w_cpu_rd    = w_cpu_ready & cpu_rden & ~cpu_wren;

  // The copy engine only borrows port A in cycles the PPU leaves idle.
  assign w_cp_issue  = (r_state == S_COPY) & ~ppu_rd_en & ~r_cp_idx[ADDR_W];
  assign w_copy_last = r_cp_wr_pend & (r_cp_waddr == {ADDR_W{1'b1}});

  assign w_a_re   = ppu_rd_en | w_cp_issue;
  assign w_addr_a = {r_front_sel, (ppu_rd_en ? ppu_rd_addr : r_cp_idx[ADDR_W-1:0])};

  // Copy writes and CPU accesses are exclusive: the CPU is held off for the whole COPY state.
  assign w_b_we   = w_cpu_wr | (r_cp_wr_pend & ~reset);
  assign w_addr_b = {~r_front_sel, (r_cp_wr_pend ? r_cp_waddr : cpu_addr)};
  assign w_b_data = r_cp_wr_pend ? r_q_a : cpu_wrdata;
  assign w_b_be   = r_cp_wr_pend ? {NB{1'b1}} : cpu_byteena;

  always_ff @(posedge clk) begin
    if (w_b_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_b_be[b]) r_mem[w_addr_b][b*8 +: 8] <= w_b_data[b*8 +: 8];
      end
    end
    if (w_a_re)   r_q_a <= r_mem[w_addr_a];
    if (w_cpu_rd) r_q_b <= r_mem[w_addr_b];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_swap_now      = 1'b0;
    w_swap_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (swap_req) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (vblank_start) begin
          w_swap_now = 1'b1;
          if (SYNC_ON_SWAP != 0) begin
            w_state_nxt = S_COPY;
          end else begin
            w_state_nxt     = S_IDLE;
            w_swap_done_nxt = 1'b1;
          end
        end
      end
      S_COPY: begin
        if (w_copy_last) begin
          w_state_nxt     = S_IDLE;
          w_swap_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_front_sel   <= 1'b0;
      r_cp_idx      <= '0;
      r_cp_wr_pend  <= 1'b0;
      r_cp_waddr    <= '0;
      r_swap_done   <= 1'b0;
      r_cpu_rdvalid <= 1'b0;
    end else begin
      r_swap_done   <= w_swap_done_nxt;
      r_cpu_rdvalid <= w_cpu_rd;
      r_cp_wr_pend  <= w_cp_issue;
      if (w_swap_now) begin
        r_front_sel <= ~r_front_sel;
        r_cp_idx    <= '0;
      end else if (w_cp_issue) begin
        r_cp_idx   <= r_cp_idx + (ADDR_W+1)'(1);
        r_cp_waddr <= r_cp_idx[ADDR_W-1:0];
      end
    end
  end

  assign ppu_rd_data  = r_q_a;
  assign cpu_rddata   = r_q_b;
  assign cpu_rdvalid  = r_cpu_rdvalid;
  assign cpu_ready    = w_cpu_ready;
  assign swap_pending = (r_state == S_PEND);
  assign copy_busy    = (r_state == S_COPY);
  assign swap_done    = r_swap_done;
  assign front_sel    = r_front_sel;

endmodule

// File: tb/tb_vram_dbuf_bank.sv
// tb/tb_vram_dbuf_bank.sv - randomized bench for vram_dbuf_bank against a two-buffer reference model
module tb_vram_dbuf_bank;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ppu_rd_en;
  logic [AW-1:0] ppu_rd_addr;
  logic [DW-1:0] ppu_rd_data;
  logic          cpu_wren;
  logic          cpu_rden;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wrdata;
  logic [7:0]    cpu_byteena;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rddata;
  logic          cpu_rdvalid;
  logic          swap_req;
  logic          vblank_start;
  logic          swap_pending;
  logic          copy_busy;
  logic          swap_done;
  logic          front_sel;

  vram_dbuf_bank #(.DATA_W(DW), .ADDR_W(AW), .SYNC_ON_SWAP(1)) dut (
    .clk(clk), .reset(reset),
    .ppu_rd_en(ppu_rd_en), .ppu_rd_addr(ppu_rd_addr), .ppu_rd_data(ppu_rd_data),
    .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_byteena(cpu_byteena), .cpu_ready(cpu_ready),
    .cpu_rddata(cpu_rddata), .cpu_rdvalid(cpu_rdvalid),
    .swap_req(swap_req), .vblank_start(vblank_start), .swap_pending(swap_pending),
    .copy_busy(copy_busy), .swap_done(swap_done), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  // Reference model: two logical buffers indexed by physical half, plus which half is front.
  logic [DW-1:0] m_mem [0:1][0:DEPTH-1];
  int            m_front;
  int            n_err = 0;
  int            n_chk = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [7:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs;
    ppu_rd_en = 0; ppu_rd_addr = '0; cpu_wren = 0; cpu_rden = 0; cpu_addr = '0;
    cpu_wrdata = '0; cpu_byteena = '0; swap_req = 0; vblank_start = 0;
  endtask

  task automatic cpu_write(input int a, input logic [DW-1:0] d, input logic [7:0] be);
    cpu_wren = 1; cpu_addr = AW'(a); cpu_wrdata = d; cpu_byteena = be;
    m_mem[1-m_front][a] = merge(m_mem[1-m_front][a], d, be);
    tick;
    cpu_wren = 0;
  endtask

  task automatic cpu_read_check(input string tag, input int a, input logic [DW-1:0] exp);
    cpu_rden = 1; cpu_addr = AW'(a);
    tick;
    cpu_rden = 0;
    check({tag, "_valid"}, DW'(cpu_rdvalid), DW'(1));
    check(tag, cpu_rddata, exp);
  endtask

  task automatic ppu_read_check(input string tag, input int a);
    ppu_rd_en = 1; ppu_rd_addr = AW'(a);
    tick;
    ppu_rd_en = 0;
    check(tag, ppu_rd_data, m_mem[m_front][a]);
  endtask

  // swap_req, some idle cycles, then vblank; returns right after the swap edge
  task automatic do_swap(input int gap);
    swap_req = 1; tick; swap_req = 0;
    check("swap_pend", DW'(swap_pending), DW'(1));
    for (int i = 0; i < gap; i++) tick;
    vblank_start = 1; tick; vblank_start = 0;
    m_front = 1 - m_front;
    check("swap_front", DW'(front_sel), DW'(m_front));
    check("swap_busy", DW'(copy_busy), DW'(1));
  endtask

  // mode 0: PPU idle; 1: PPU reads on alternate cycles starting with the first; 2: stray swap/vblank
  task automatic run_copy(input int mode, output int cycles);
    logic          was_en;
    logic [AW-1:0] pa;
    logic          ready_ok;
    cycles = -1;
    ready_ok = 1;
    for (int k = 1; k <= 80; k++) begin
      ppu_rd_en    = (mode == 1) ? ((k % 2) == 1) : 1'b0;
      ppu_rd_addr  = AW'($urandom_range(0, DEPTH-1));
      cpu_wren     = 1;
      cpu_addr     = AW'($urandom_range(0, DEPTH-1));
      cpu_wrdata   = {$urandom, $urandom};
      cpu_byteena  = 8'hFF;
      swap_req     = (mode == 2) && (k == 4);
      vblank_start = (mode == 2) && (k == 4);
      was_en = ppu_rd_en;
      pa     = ppu_rd_addr;
      tick;
      if (was_en) check("copy_ppu", ppu_rd_data, m_mem[m_front][pa]);
      if (swap_done) begin
        cycles = k;
        break;
      end
      if (cpu_ready) ready_ok = 0;
    end
    idle_inputs();
    check("copy_ready_low", DW'(ready_ok), DW'(1));
    check("done_ready", DW'(cpu_ready), DW'(1));
    check("done_busy", DW'(copy_busy), DW'(0));
    for (int i = 0; i < DEPTH; i++) m_mem[1-m_front][i] = m_mem[m_front][i];
  endtask

  initial begin
    int            n;
    int            op;
    int            a;
    int            pa;
    logic          pen;
    logic [DW-1:0] d;
    logic [7:0]    be;
    logic          exp_v;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_pp;
    logic          saw_done;

    idle_inputs();
    m_front = 0;
    reset = 1;
    tick; tick;
    check("rst_front", DW'(front_sel), DW'(0));
    check("rst_pend", DW'(swap_pending), DW'(0));
    check("rst_busy", DW'(copy_busy), DW'(0));
    check("rst_done", DW'(swap_done), DW'(0));
    check("rst_rdvalid", DW'(cpu_rdvalid), DW'(0));
    check("rst_ready", DW'(cpu_ready), DW'(1));
    reset = 0;
    tick;

    cpu_write(3, 64'hA5, 8'hFF);
    cpu_read_check("rd_a5", 3, 64'hA5);
    tick;
    check("rdvalid_pulse", DW'(cpu_rdvalid), DW'(0));

    for (int i = 0; i < DEPTH; i++) if (i != 3) cpu_write(i, {$urandom, $urandom}, 8'hFF);

    do_swap(10);
    check("swap_ready", DW'(cpu_ready), DW'(0));
    run_copy(0, n);
    check("copy_latency", DW'(n), DW'(DEPTH+1));
    tick;
    check("done_pulse", DW'(swap_done), DW'(0));
    check("ppu_a5_after", ppu_rd_data, ppu_rd_data);
    ppu_read_check("ppu_a5", 3);
    check("ppu_a5_lit", ppu_rd_data, 64'hA5);
    cpu_read_check("back_a5", 3, 64'hA5);

    cpu_write(0, '0, 8'hFF);
    cpu_write(0, {DW{1'b1}}, 8'h01);
    cpu_read_check("byteena", 0, 64'hFF);
    cpu_write(3, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    ppu_read_check("ppu_front_iso", 3);
    check("ppu_front_lit", ppu_rd_data, 64'hA5);

    for (int k = 0; k < 200; k++) begin
      op  = $urandom_range(0, 3);
      a   = $urandom_range(0, DEPTH-1);
      d   = {$urandom, $urandom};
      be  = 8'($urandom_range(0, 255));
      pen = 1'($urandom_range(0, 1));
      pa  = $urandom_range(0, DEPTH-1);
      cpu_wren = (op == 1) || (op == 3);
      cpu_rden = (op == 2) || (op == 3);
      cpu_addr = AW'(a); cpu_wrdata = d; cpu_byteena = be;
      ppu_rd_en = pen; ppu_rd_addr = AW'(pa);
      exp_v  = (op == 2);
      exp_rd = m_mem[1-m_front][a];
      exp_pp = m_mem[m_front][pa];
      if (cpu_wren) m_mem[1-m_front][a] = merge(m_mem[1-m_front][a], d, be);
      tick;
      check("rnd_rdvalid", DW'(cpu_rdvalid), DW'(exp_v));
      if (exp_v) check("rnd_rddata", cpu_rddata, exp_rd);
      if (pen) check("rnd_ppu", ppu_rd_data, exp_pp);
    end
    idle_inputs();

    do_swap(2);
    run_copy(1, n);
    check("copy_contended", DW'(n), DW'(2*DEPTH+1));
    for (int i = 0; i < DEPTH; i++) cpu_read_check("sync_back", i, m_mem[m_front][i]);

    swap_req = 1; vblank_start = 1; tick; swap_req = 0; vblank_start = 0;
    check("same_cyc_pend", DW'(swap_pending), DW'(1));
    check("same_cyc_front", DW'(front_sel), DW'(m_front));
    tick;
    swap_req = 1; tick; swap_req = 0;
    check("pend_hold", DW'(swap_pending), DW'(1));
    vblank_start = 1; tick; vblank_start = 0;
    m_front = 1 - m_front;
    check("pend_swap_front", DW'(front_sel), DW'(m_front));
    run_copy(2, n);
    check("copy_latency2", DW'(n), DW'(DEPTH+1));
    tick; tick;
    check("no_requeue", DW'(swap_pending), DW'(0));
    check("single_swap", DW'(front_sel), DW'(m_front));

    do_swap(1);
    run_copy(0, n);
    check("copy_latency3", DW'(n), DW'(DEPTH+1));

    do_swap(1);
    for (int k = 0; k < 5; k++) tick;
    reset = 1; tick; reset = 0;
    m_front = 0;
    check("abort_busy", DW'(copy_busy), DW'(0));
    check("abort_pend", DW'(swap_pending), DW'(0));
    check("abort_front", DW'(front_sel), DW'(0));
    check("abort_ready", DW'(cpu_ready), DW'(1));
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (swap_done) saw_done = 1;
      tick;
    end
    check("abort_no_done", DW'(saw_done), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
